// File: rtl/rv32_imem_arb.sv
// rv32_imem_arb
//   Arbitrates one single-port synchronous instruction/data memory between a
//   fetch port (read-only) and a data/loader port (read or byte-masked write).
//   The fetch port normally has priority. A saturating starve counter tracks
//   how long the data port has been refused. Once it reaches STARVE_LIMIT, the
//   data port wins the next contested cycle.
//
// Ports
//   clk, reset       clock and synchronous active-high reset
//   f_req/f_addr     fetch read request and word address
//   f_flush          drop the response belonging to this cycle's fetch grant
//   f_gnt            fetch accepted this cycle (combinational)
//   f_rvalid/f_rdata fetch read response, one cycle after the grant
//   fetch_stall      fetch requested but not granted this cycle
//   d_req/d_we       data request; d_we=1 write, 0 read
//   d_addr/d_wdata   data word address and write data
//   d_wstrb          byte write enables for data writes
//   d_gnt            data accepted this cycle (combinational)
//   d_rvalid/d_rdata data read response, one cycle after the grant
//   mem_*            single-port memory interface; mem_rdata valid one
//                    cycle after mem_en
module rv32_imem_arb #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              fetch_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        F_PRI   = 1'b0,
        D_FORCE = 1'b1
    } state_t;

    state_t     state_reg;
    logic [3:0] starve_reg;
    logic [3:0] starve_next;
    logic       f_pend_reg;
    logic       d_pend_reg;
    logic       f_win;
    logic       d_win;
    logic       d_wr_win;

    // Priority arbitration. No grant is issued while reset is high.
    always_comb begin
        f_win = 1'b0;
        d_win = 1'b0;
        if (!reset) begin
            if (state_reg == D_FORCE) begin
                if (d_req)      d_win = 1'b1;
                else if (f_req) f_win = 1'b1;
            end else begin
                if (f_req)      f_win = 1'b1;
                else if (d_req) d_win = 1'b1;
            end
        end
    end

    // The counter counts refused data cycles and stops at the limit. It
    // restarts whenever the data port is served or stops asking.
    always_comb begin
        starve_next = starve_reg;
        if (!d_req || d_win) begin
            starve_next = 4'd0;
        end else if (starve_reg >= LIMIT) begin
            starve_next = LIMIT;
        end else begin
            starve_next = starve_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= F_PRI;
            starve_reg <= 4'd0;
            f_pend_reg <= 1'b0;
            d_pend_reg <= 1'b0;
        end else begin
            starve_reg <= starve_next;
            // A flushed fetch still occupies the memory slot, but its data is
            // not forwarded.
            f_pend_reg <= f_win & ~f_flush;
            d_pend_reg <= d_win & ~d_we;
            case (state_reg)
                F_PRI: begin
                    if (starve_next == LIMIT) state_reg <= D_FORCE;
                end
                D_FORCE: begin
                    if (d_win || !d_req) state_reg <= F_PRI;
                end
                default: state_reg <= F_PRI;
            endcase
        end
    end

    assign f_gnt       = f_win;
    assign d_gnt       = d_win;
    assign fetch_stall = f_req & ~f_win;

    // Memory port is steered combinationally from whichever side won.
    assign d_wr_win  = d_win & d_we;
    assign mem_en    = f_win | d_win;
    assign mem_addr  = d_win ? d_addr : f_addr;
    assign mem_wdata = d_win ? d_wdata : 32'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_we
            assign mem_we[gi] = d_wr_win & d_wstrb[gi];
        end
    endgenerate

    // Reset in the response cycle discards the outstanding read.
    assign f_rvalid = f_pend_reg & ~reset;
    assign d_rvalid = d_pend_reg & ~reset;
    assign f_rdata  = f_rvalid ? mem_rdata : 32'd0;
    assign d_rdata  = d_rvalid ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_rv32_imem_arb.sv
// Testbench for rv32_imem_arb. It contains a behavioural synchronous memory,
// a reference copy of that memory that the bench updates itself, and a
// response scoreboard. Expected read data is queued at the grant cycle and is
// compared when the response appears one cycle later.
module tb_rv32_imem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [7:0]  f_addr;
    logic        f_flush;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        fetch_stall;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    logic [31:0] f_q [$];
    logic [31:0] d_q [$];
    logic        f_exp_reg = 1'b0;
    logic        d_exp_reg = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32_imem_arb #(
        .ADDR_W      (8),
        .STARVE_LIMIT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_flush    (f_flush),
        .f_gnt      (f_gnt),
        .f_rvalid   (f_rvalid),
        .f_rdata    (f_rdata),
        .fetch_stall(fetch_stall),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port synchronous memory: registered read with byte-lane writes.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle. The inputs have already been driven. The arguments give
    // the grant that the bench expects for this cycle. Checks are made at the
    // negedge. The task then advances to just after the next posedge.
    task automatic do_cycle(input logic ef, input logic ed);
        logic [31:0] exp_data;
        logic [31:0] w;
        @(negedge clk);
        // Responses to the previous cycle's grants
        check_val("f_rvalid", 32'(f_rvalid), 32'(f_exp_reg & ~reset));
        if (f_exp_reg) begin
            exp_data = f_q.pop_front();
            if (!reset && f_rvalid) begin
                check_val("f_rdata", f_rdata, exp_data);
                $display("fetch response data=%h", f_rdata);
            end
        end else begin
            check_val("f_rdata_idle", f_rdata, 32'd0);
        end
        check_val("d_rvalid", 32'(d_rvalid), 32'(d_exp_reg & ~reset));
        if (d_exp_reg) begin
            exp_data = d_q.pop_front();
            if (!reset && d_rvalid) begin
                check_val("d_rdata", d_rdata, exp_data);
                $display("data response data=%h", d_rdata);
            end
        end else begin
            check_val("d_rdata_idle", d_rdata, 32'd0);
        end
        // Grants and memory-side steering for this cycle
        check_val("f_gnt", 32'(f_gnt), 32'(ef));
        check_val("d_gnt", 32'(d_gnt), 32'(ed));
        check_val("fetch_stall", 32'(fetch_stall), 32'(f_req & ~ef));
        check_val("mem_en", 32'(mem_en), 32'(ef | ed));
        check_val("mem_we", 32'(mem_we), (ed && d_we) ? 32'(d_wstrb) : 32'd0);
        if (ef || ed) check_val("mem_addr", 32'(mem_addr), ed ? 32'(d_addr) : 32'(f_addr));
        // Queue the expected responses
        f_exp_reg = ef & ~f_flush;
        if (f_exp_reg) f_q.push_back(ref_mem[f_addr]);
        d_exp_reg = ed & ~d_we;
        if (d_exp_reg) d_q.push_back(ref_mem[d_addr]);
        if (ed && d_we) begin
            w = ref_mem[d_addr];
            for (int b = 0; b < 4; b++) begin
                if (d_wstrb[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
            end
            ref_mem[d_addr] = w;
        end
        if (ef) $display("fetch grant addr=%h flush=%0d", f_addr, f_flush);
        if (ed) $display("data grant addr=%h we=%0d wdata=%h wstrb=%b", d_addr, d_we, d_wdata, d_wstrb);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[16] = 32'h0000_0013; ref_mem[16] = 32'h0000_0013;
        mem[3]  = 32'h0000_0000; ref_mem[3]  = 32'h0000_0000;
        mem_rdata = 32'd0;

        // Reset with both ports requesting: no grants, memory idle
        reset = 1'b1; f_req = 1'b1; f_addr = 8'h10; f_flush = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05; d_wdata = 32'd0; d_wstrb = 4'h0;
        do_cycle(1'b0, 1'b0);
        do_cycle(1'b0, 1'b0);

        // A single fetch is granted at once and returns data one cycle later
        reset = 1'b0; d_req = 1'b0;
        do_cycle(1'b1, 1'b0);
        f_req = 1'b0;
        do_cycle(1'b0, 1'b0);

        // Contention: four fetch grants, then the data port is forced through
        f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) do_cycle(1'b1, 1'b0);
            do_cycle(1'b0, 1'b1);
        end
        do_cycle(1'b1, 1'b0);
        f_req = 1'b0; d_req = 1'b0;
        do_cycle(1'b0, 1'b0);

        // Byte-masked write, then read back
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h03; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        do_cycle(1'b0, 1'b1);
        d_we = 1'b0; d_wdata = 32'd0; d_wstrb = 4'h0;
        do_cycle(1'b0, 1'b1);
        d_req = 1'b0;
        do_cycle(1'b0, 1'b0);
        check_val("ref_wr_addr3", ref_mem[3], 32'h0000_BEEF);

        // A flushed fetch returns no data; the following fetch returns data
        f_req = 1'b1; f_addr = 8'h10; f_flush = 1'b1;
        do_cycle(1'b1, 1'b0);
        f_addr = 8'h11; f_flush = 1'b0;
        do_cycle(1'b1, 1'b0);
        f_req = 1'b0;
        do_cycle(1'b0, 1'b0);

        // Counter at 3 when reset arrives: after reset it must start again from 0
        f_req = 1'b1; f_addr = 8'h20; d_req = 1'b1; d_addr = 8'h07;
        for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b0);
        reset = 1'b1;
        do_cycle(1'b0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) do_cycle(1'b1, 1'b0);
        do_cycle(1'b0, 1'b1);

        // Counter at 3, data read granted, reset in the response cycle
        for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b0);
        f_req = 1'b0;
        do_cycle(1'b0, 1'b1);
        f_req = 1'b1; reset = 1'b1;
        do_cycle(1'b0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) do_cycle(1'b1, 1'b0);
        do_cycle(1'b0, 1'b1);
        f_req = 1'b0; d_req = 1'b0;
        do_cycle(1'b0, 1'b0);
        do_cycle(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
